pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-look-ahead adder/subtractor: the successor to our fixed 4-bit combinational CLA.
- Operand is split into GROUP-bit look-ahead groups, with one register stage per group; the carry ripples stage-to-stage while the operands are skewed.
- Valid/ready handshake on both sides; one result per cycle when not stalled.
- Sits in datapaths needing wide adds at high clock rate.

---
 rtl/pipelined_cla_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor: GROUP-bit CLA per stage, NG=WIDTH/GROUP stages.
// Ports: clk, rst; in_valid/in_ready, a, b, cin, sub; out_valid/out_ready, sum, cout, ovf.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  generate
    if (WIDTH % GROUP != 0) begin : g_bad_param
      $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end
  endgenerate

  // Returns {carry out, carry into MSB, group sum}.
  // Each carry is the flattened look-ahead sum of products.
  function automatic logic [GROUP+1:0] cla_group(
    input logic [GROUP-1:0] x,
    input logic [GROUP-1:0] y,
    input logic             ci
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             t;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      t      = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (t & g[j]);
        t      = t & p[j];
      end
      c[i+1] = c[i+1] | (t & ci);
    end
    return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
  endfunction

  logic             en;
  logic [NG-1:0]    v_q;
  logic [NG-1:0]    c_q;
  logic [NG-1:0]    c_n;
  logic             ovf_q;
  logic             ovf_n;
  logic [WIDTH-1:0] a_q [NG];
  logic [WIDTH-1:0] b_q [NG];
  logic [WIDTH-1:0] s_q [NG];
  logic [WIDTH-1:0] a_n [NG];
  logic [WIDTH-1:0] b_n [NG];
  logic [WIDTH-1:0] s_n [NG];
  logic [WIDTH-1:0] xa  [NG];
  logic [WIDTH-1:0] xb  [NG];
  logic [WIDTH-1:0] xs  [NG];
  logic [NG-1:0]    xc;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[NG-1];
  assign sum       = s_q[NG-1];
  assign cout      = c_q[NG-1];
  assign ovf       = ovf_q;

  // Stage inputs: stage 0 takes the (possibly inverted) port
  // operands, later stages take the previous stage registers.
  always_comb begin
    xa[0] = a;
    xb[0] = sub ? ~b : b;
    xc[0] = sub | cin;
    xs[0] = '0;
    for (int k = 1; k < NG; k++) begin
      xa[k] = a_q[k-1];
      xb[k] = b_q[k-1];
      xc[k] = c_q[k-1];
      xs[k] = s_q[k-1];
    end
  end

  always_comb begin : stage_logic
    logic [GROUP+1:0] r;
    r     = '0;
    ovf_n = 1'b0;
    for (int k = 0; k < NG; k++) begin
      r = cla_group(xa[k][k*GROUP +: GROUP],
                    xb[k][k*GROUP +: GROUP], xc[k]);
      a_n[k] = xa[k];
      b_n[k] = xb[k];
      c_n[k] = r[GROUP+1];
      s_n[k] = xs[k];
      s_n[k][k*GROUP +: GROUP] = r[GROUP-1:0];
      if (k == NG - 1) begin
        ovf_n = r[GROUP+1] ^ r[GROUP];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      s_q   <= '{default: '0};
    end else if (en) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < NG; k++) begin
        v_q[k] <= v_q[k-1];
      end
      c_q   <= c_n;
      ovf_q <= ovf_n;
      a_q   <= a_n;
      b_q   <= b_n;
      s_q   <= s_n;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder at 16/4, 4/4 and 32/8.
// Scoreboard queues per instance; directed tasks run in sequence.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic        iv16 = 0, ir16, ci16 = 0, sb16 = 0;
  logic        ov16, or16 = 0, co16, of16;
  logic [15:0] a16 = 0, b16 = 0, s16;

  logic        iv4 = 0, ir4, ci4 = 0, sb4 = 0;
  logic        ov4, or4 = 1, co4, of4;
  logic [3:0]  a4 = 0, b4 = 0, s4;

  logic        iv32 = 0, ir32, ci32 = 0, sb32 = 0;
  logic        ov32, or32 = 1, co32, of32;
  logic [31:0] a32 = 0, b32 = 0, s32;

  logic [33:0] q16 [$];
  logic [33:0] q4  [$];
  logic [33:0] q32 [$];

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) d16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(ci16), .sub(sb16),
    .out_valid(ov16), .out_ready(or16),
    .sum(s16), .cout(co16), .ovf(of16));

  pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(ci4), .sub(sb4),
    .out_valid(ov4), .out_ready(or4),
    .sum(s4), .cout(co4), .ovf(of4));

  pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) d32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(ci32), .sub(sb32),
    .out_valid(ov32), .out_ready(or32),
    .sum(s32), .cout(co32), .ovf(of32));

  // Behavioural reference: {ovf, cout, sum} zero-extended to 32 bits.
  function automatic logic [33:0] model(
    input int w, input logic [31:0] x, input logic [31:0] y,
    input logic c, input logic s);
    logic [32:0] m, full;
    logic [31:0] yx, xs, r;
    logic c0, co, ov;
    m    = (33'd1 << w) - 33'd1;
    xs   = x & m[31:0];
    yx   = (s ? ~y : y) & m[31:0];
    c0   = s ? 1'b1 : c;
    full = {1'b0, xs} + {1'b0, yx} + {32'd0, c0};
    r    = full[31:0] & m[31:0];
    co   = full[w];
    ov   = (xs[w-1] == yx[w-1]) && (r[w-1] != xs[w-1]);
    return {ov, co, r};
  endfunction

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst) begin
      if (ov16 && or16) begin
        n_total++;
        if (q16.size() == 0) begin
          $display("FAIL sb16_extra: got %h want none", s16);
        end else begin
          e = q16.pop_front();
          if ({of16, co16, 16'd0, s16} !== e)
            $display("FAIL sb16: got %h want %h",
                     {of16, co16, 16'd0, s16}, e);
          else n_pass++;
        end
      end
      if (iv16 && ir16)
        q16.push_back(model(16, {16'd0, a16}, {16'd0, b16}, ci16, sb16));
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst) begin
      if (ov4 && or4) begin
        n_total++;
        if (q4.size() == 0) begin
          $display("FAIL sb4_extra: got %h want none", s4);
        end else begin
          e = q4.pop_front();
          if ({of4, co4, 28'd0, s4} !== e)
            $display("FAIL sb4: got %h want %h",
                     {of4, co4, 28'd0, s4}, e);
          else n_pass++;
        end
      end
      if (iv4 && ir4)
        q4.push_back(model(4, {28'd0, a4}, {28'd0, b4}, ci4, sb4));
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst) begin
      if (ov32 && or32) begin
        n_total++;
        if (q32.size() == 0) begin
          $display("FAIL sb32_extra: got %h want none", s32);
        end else begin
          e = q32.pop_front();
          if ({of32, co32, s32} !== e)
            $display("FAIL sb32: got %h want %h", {of32, co32, s32}, e);
          else n_pass++;
        end
      end
      if (iv32 && ir32)
        q32.push_back(model(32, a32, b32, ci32, sb32));
    end
  end

  task automatic send16(input logic [15:0] x, input logic [15:0] y,
                        input logic c, input logic s);
    a16 = x; b16 = y; ci16 = c; sb16 = s; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; or16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({ov16, s16, co16, of16} !== 19'd0)
      $display("FAIL reset16: got %h want 0", {ov16, s16, co16, of16});
    else n_pass++;
    n_total++;
    if ({ov4, ov32, s32, co32, of32} !== 36'd0)
      $display("FAIL reset_other: got %h want 0",
               {ov4, ov32, s32, co32, of32});
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (ir16 !== 1'b1) $display("FAIL reset_ready: got %b want 1", ir16);
    else n_pass++;
    or16 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    int lat;
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    lat = 1;
    while (!ov16 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_total++;
    if (lat !== 4) $display("FAIL latency: got %0d want 4", lat);
    else n_pass++;
    n_total++;
    if ({s16, co16, of16} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL wrap: got %h want %h",
               {s16, co16, of16}, {16'h0000, 1'b1, 1'b0});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    int t;
    send16(16'h0005, 16'h0007, 1'b0, 1'b1);
    t = 0;
    while (!ov16 && t < 20) begin @(posedge clk); #1; t++; end
    n_total++;
    if ({s16, co16, of16} !== {16'hFFFE, 1'b0, 1'b0})
      $display("FAIL sub5m7: got %h want %h",
               {s16, co16, of16}, {16'hFFFE, 1'b0, 1'b0});
    else n_pass++;
    @(posedge clk); #1;
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    t = 0;
    while (!ov16 && t < 20) begin @(posedge clk); #1; t++; end
    n_total++;
    if ({s16, co16, of16} !== {16'h8000, 1'b0, 1'b1})
      $display("FAIL ovf_pos: got %h want %h",
               {s16, co16, of16}, {16'h8000, 1'b0, 1'b1});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int sent;
    logic [17:0] held;
    sent = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      or16 = !(c >= 5 && c <= 7);
      if (sent < 8) begin
        iv16 = 1'b1; a16 = 16'(sent); b16 = 16'(sent * 4096);
        ci16 = 1'b0; sb16 = 1'b0;
      end else iv16 = 1'b0;
      #1;
      if (c >= 5 && c <= 7) begin
        n_total++;
        if (ir16 !== 1'b0) $display("FAIL stall_ready: got %b want 0", ir16);
        else n_pass++;
        if (c == 5) held = {ov16, co16, s16};
        else begin
          n_total++;
          if ({ov16, co16, s16} !== held)
            $display("FAIL stall_hold: got %h want %h",
                     {ov16, co16, s16}, held);
          else n_pass++;
        end
      end
      if (iv16 && ir16) sent++;
      @(posedge clk); #1;
      if (sent == 8 && q16.size() == 0) break;
    end
    iv16 = 1'b0; or16 = 1'b1;
    n_total++;
    if (sent !== 8 || q16.size() !== 0)
      $display("FAIL b2b_drain: got sent=%0d left=%0d want 8/0",
               sent, q16.size());
    else n_pass++;
  endtask

  task automatic test_flush;
    int stale;
    or16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv16 = 1'b1; a16 = 16'(i + 100); b16 = 16'h0011;
      ci16 = 1'b1; sb16 = 1'b0;
      @(posedge clk); #1;
    end
    iv16 = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (ov16 !== 1'b1) $display("FAIL flush_pre: got %b want 1", ov16);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({ov16, s16} !== 17'd0)
      $display("FAIL flush_now: got %h want 0", {ov16, s16});
    else n_pass++;
    rst = 1'b0;
    q16.delete();
    or16 = 1'b1;
    #1;
    n_total++;
    if (ir16 !== 1'b1) $display("FAIL flush_ready: got %b want 1", ir16);
    else n_pass++;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov16) stale++;
    end
    n_total++;
    if (stale !== 0) $display("FAIL flush_stale: got %0d want 0", stale);
    else n_pass++;
  endtask

  task automatic test_exhaustive4;
    int gaps;
    logic [8:0] t;
    gaps = 0; or4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      t = 9'(i);
      iv4 = 1'b1; ci4 = t[8]; a4 = t[7:4]; b4 = t[3:0]; sb4 = 1'b0;
      #1;
      if (i > 0 && !ov4) gaps++;
      @(posedge clk); #1;
    end
    iv4 = 1'b0;
    #1;
    if (!ov4) gaps++;
    n_total++;
    if (gaps !== 0) $display("FAIL exh4_gaps: got %0d want 0", gaps);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (q4.size() !== 0 || ov4 !== 1'b0)
      $display("FAIL exh4_drain: got left=%0d v=%b want 0/0",
               q4.size(), ov4);
    else n_pass++;
  endtask

  task automatic test_random32;
    int sent;
    sent = 0;
    for (int c = 0; c < 6000 && sent < 1000; c++) begin
      or32 = ($urandom_range(0, 3) != 0);
      iv32 = ($urandom_range(0, 4) != 0);
      a32 = $urandom; b32 = $urandom;
      ci32 = 1'($urandom_range(0, 1));
      sb32 = 1'($urandom_range(0, 1));
      if (c % 97 == 0) begin a32 = 32'h7FFFFFFF; b32 = 32'h00000001; end
      #1;
      if (iv32 && ir32) sent++;
      @(posedge clk); #1;
    end
    iv32 = 1'b0; or32 = 1'b1;
    for (int c = 0; c < 50 && q32.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (sent !== 1000 || q32.size() !== 0)
      $display("FAIL rnd32_drain: got sent=%0d left=%0d want 1000/0",
               sent, q32.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_flush();
    test_exhaustive4();
    test_random32();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
